// File: rtl/riscv_pkg.sv
// RV32I decode types: ALU ops, branch kinds, control word, opcodes and small lookup helpers.
package riscv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6
    } branch_t;

    localparam logic [1:0] JUMP_NONE = 2'd0;
    localparam logic [1:0] JUMP_JAL  = 2'd1;
    localparam logic [1:0] JUMP_JALR = 2'd2;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        branch_t     branch_type;
        logic [1:0]  jump;
        logic        reg_write;
        logic        illegal;
    } ctrl_t;

    // alt selects SUB/SRA when instruction bit 30 is set on the relevant funct3
    function automatic alu_op_t base_alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t m_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational RV32I decoder: control word, sign-extended immediate and source usage.
// Macro RV32M_EN enables decoding of the M-extension multiply/divide ops.
module instruction_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        zero_rs1
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        illegal;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        imm         = '0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        zero_rs1    = 1'b0;
        illegal     = 1'b0;

        case (opcode)
            OPC_LUI: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                imm              = imm_u;
                zero_rs1         = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alu_src_pc  = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                imm              = imm_u;
            end
            OPC_JAL: begin
                ctrl.alu_src_pc  = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.jump        = JUMP_JAL;
                ctrl.reg_write   = 1'b1;
                imm              = imm_j;
            end
            OPC_JALR: begin
                illegal          = (funct3 != 3'b000);
                ctrl.alu_src_imm = 1'b1;
                ctrl.jump        = JUMP_JALR;
                ctrl.reg_write   = 1'b1;
                uses_rs1         = 1'b1;
                imm              = imm_i;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  ctrl.branch_type = BR_EQ;
                    3'b001:  ctrl.branch_type = BR_NE;
                    3'b100:  ctrl.branch_type = BR_LT;
                    3'b101:  ctrl.branch_type = BR_GE;
                    3'b110:  ctrl.branch_type = BR_LTU;
                    3'b111:  ctrl.branch_type = BR_GEU;
                    default: illegal = 1'b1;
                endcase
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = imm_b;
            end
            OPC_LOAD: begin
                illegal           = (funct3 == 3'b011) || (funct3[2] && funct3[1]);
                ctrl.mem_read     = 1'b1;
                ctrl.mem_size     = funct3[1:0];
                ctrl.mem_unsigned = funct3[2];
                ctrl.alu_src_imm  = 1'b1;
                ctrl.reg_write    = 1'b1;
                uses_rs1          = 1'b1;
                imm               = imm_i;
            end
            OPC_STORE: begin
                illegal          = funct3[2] || (funct3[1:0] == 2'b11);
                ctrl.mem_write   = 1'b1;
                ctrl.mem_size    = funct3[1:0];
                ctrl.alu_src_imm = 1'b1;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                imm              = imm_s;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                ctrl.alu_op      = base_alu_op(funct3, (funct3 == 3'b101) && instruction[30]);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                uses_rs1         = 1'b1;
                imm              = imm_i;
            end
            OPC_OP: begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                if (funct7 == 7'b0000000)
                    ctrl.alu_op = base_alu_op(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    ctrl.alu_op = base_alu_op(funct3, 1'b1);
`ifdef RV32M_EN
                else if (funct7 == 7'b0000001)
                    ctrl.alu_op = m_alu_op(funct3);
`endif
                else
                    illegal = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE is ordered trivially in this in-order pipe, so it issues as a NOP
                illegal = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase

        if (instruction[1:0] != 2'b11)
            illegal = 1'b1;

        if (illegal) begin
            ctrl        = '0;
            ctrl.alu_op = ALU_ADD;
            uses_rs1    = 1'b0;
            uses_rs2    = 1'b0;
            zero_rs1    = 1'b0;
        end
        ctrl.illegal = illegal;

        if (instruction[11:7] == 5'd0)
            ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: fetch/execute handshake, load-use interlock, flush and ID/EX register.
// Macro RV32M_EN (see instruction_decoder) enables the M-extension ops.
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instruction,
    output logic        fetch_ready,
    output logic [4:0]  rs1_address,
    output logic [4:0]  rs2_address,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1_address,
    output logic [4:0]  ex_rs2_address,
    output logic [4:0]  ex_rd_address,
    output logic [4:0]  ex_alu_op,
    output logic        ex_alu_src_imm,
    output logic        ex_alu_src_pc,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [1:0]  ex_mem_size,
    output logic        ex_mem_unsigned,
    output logic [2:0]  ex_branch_type,
    output logic [1:0]  ex_jump,
    output logic        ex_reg_write,
    output logic        ex_illegal
);

    ctrl_t       dec_ctrl;
    ctrl_t       ex_ctrl;
    logic [31:0] dec_imm;
    logic        uses_rs1, uses_rs2, zero_rs1;
    logic        advance, hazard;

    instruction_decoder u_decoder (
        .instruction (fetch_instruction),
        .ctrl        (dec_ctrl),
        .imm         (dec_imm),
        .uses_rs1    (uses_rs1),
        .uses_rs2    (uses_rs2),
        .zero_rs1    (zero_rs1)
    );

    assign rs1_address = fetch_instruction[19:15];
    assign rs2_address = fetch_instruction[24:20];

    assign advance = !ex_valid || ex_ready;
    assign hazard  = ex_valid && ex_ctrl.mem_read && (ex_rd_address != 5'd0) &&
                     ((uses_rs1 && ex_rd_address == rs1_address) ||
                      (uses_rs2 && ex_rd_address == rs2_address));
    assign fetch_ready = flush || (advance && !hazard);

    // ID/EX boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid       <= 1'b0;
            ex_pc          <= RESET_PC;
            ex_rs1_data    <= '0;
            ex_rs2_data    <= '0;
            ex_imm         <= '0;
            ex_rs1_address <= '0;
            ex_rs2_address <= '0;
            ex_rd_address  <= '0;
            ex_ctrl        <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid       <= fetch_valid;
                ex_pc          <= fetch_pc;
                ex_rs1_address <= zero_rs1 ? 5'd0 : rs1_address;
                ex_rs1_data    <= zero_rs1 ? 32'd0 : rs1_data;
                ex_rs2_address <= rs2_address;
                ex_rs2_data    <= rs2_data;
                ex_rd_address  <= fetch_instruction[11:7];
                ex_imm         <= dec_imm;
                ex_ctrl        <= dec_ctrl;
            end
        end
    end

    assign ex_alu_op       = ex_ctrl.alu_op;
    assign ex_alu_src_imm  = ex_ctrl.alu_src_imm;
    assign ex_alu_src_pc   = ex_ctrl.alu_src_pc;
    assign ex_mem_read     = ex_ctrl.mem_read;
    assign ex_mem_write    = ex_ctrl.mem_write;
    assign ex_mem_size     = ex_ctrl.mem_size;
    assign ex_mem_unsigned = ex_ctrl.mem_unsigned;
    assign ex_branch_type  = ex_ctrl.branch_type;
    assign ex_jump         = ex_ctrl.jump;
    assign ex_reg_write    = ex_ctrl.reg_write;
    assign ex_illegal      = ex_ctrl.illegal;

endmodule
